// File: rtl/l0_ctrl.sv
// l0_ctrl: sequences activation SRAM reads into the L0 FIFO bank and drains
// L0 into the systolic array, tracking L0 occupancy so it never overflows.
module l0_ctrl #(
    parameter int col    = 8,
    parameter int depth  = 8,
    parameter int addr_w = 11,
    parameter int len_w  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [len_w-1:0]  num_rows,
    input  logic              array_ready,
    output logic              sram_cen,
    output logic [addr_w-1:0] sram_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = len_w + 1;
    localparam int OCC_W = $clog2(depth + 1);
    localparam int FL_W  = $clog2(col + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [addr_w-1:0] base_q;
    logic [CNT_W-1:0]  rows_q;
    logic [CNT_W-1:0]  rq_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [OCC_W-1:0]  occ;
    logic [col-1:0]    dly;
    logic [FL_W-1:0]   flush_cnt;

    logic issue_rq;
    logic issue_rd;
    logic retire;

    // Issue decisions for this edge: SRAM read and L0 read are independent.
    always_comb begin
        issue_rq = (state == STREAM) && (rq_cnt < rows_q) && (occ < OCC_W'(depth));
        issue_rd = (state == STREAM) && (rd_cnt < wr_cnt) && array_ready;
        retire   = dly[col-1];
    end

    // Main sequencer: state, counters, stagger delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            rq_cnt    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            occ       <= '0;
            dly       <= '0;
            flush_cnt <= '0;
            sram_cen  <= 1'b1;
            sram_addr <= '0;
            l0_wr     <= 1'b0;
            l0_rd     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            sram_cen <= 1'b1;
            l0_rd    <= 1'b0;
            done     <= 1'b0;

            // SRAM read data arrives one cycle after enable; write it into L0.
            l0_wr <= ~sram_cen;
            if (!sram_cen) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end

            // A read leaves the last L0 column col cycles after its l0_rd pulse.
            dly <= {dly[col-2:0], l0_rd};
            occ <= occ + OCC_W'(issue_rq) - OCC_W'(retire);

            if (done) begin
                busy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        base_q <= base_addr;
                        rows_q <= {1'b0, num_rows};
                        rq_cnt <= '0;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= (num_rows == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (issue_rq) begin
                        sram_cen  <= 1'b0;
                        sram_addr <= base_q + addr_w'(rq_cnt);
                        rq_cnt    <= rq_cnt + CNT_W'(1);
                    end
                    if (issue_rd) begin
                        l0_rd  <= 1'b1;
                        rd_cnt <= rd_cnt + CNT_W'(1);
                        if (rd_cnt + CNT_W'(1) == rows_q) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_W'(col)) begin
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l0_ctrl.sv
// tb_l0_ctrl: directed scoreboard bench for l0_ctrl.
module tb_l0_ctrl;

    localparam int COL   = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 11;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_rows;
    logic          array_ready;
    logic          sram_cen;
    logic [AW-1:0] sram_addr;
    logic          l0_wr;
    logic          l0_rd;
    logic          busy;
    logic          done;

    l0_ctrl #(.col(COL), .depth(DEPTH), .addr_w(AW), .len_w(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .array_ready(array_ready), .sram_cen(sram_cen),
        .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] exp_q[$];
    int cen_seen = 0, wr_seen = 0, rd_seen = 0, done_seen = 0;
    bit prev_cen_low = 1'b0;
    bit prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cen_seen = 0; wr_seen = 0; rd_seen = 0; done_seen = 0;
    endtask

    // Output monitor: pops expected addresses and checks per-cycle relations.
    always @(negedge clk) begin
        if (sram_cen === 1'b0) begin
            cen_seen++;
            if (exp_q.size() == 0) check("addr_unexpected", 1, 0);
            else check("sram_addr", sram_addr, exp_q.pop_front());
        end
        check("l0_wr_align", l0_wr, prev_cen_low);
        if (l0_rd === 1'b1) begin
            check("rd_after_wr", rd_seen < wr_seen, 1);
            rd_seen++;
        end
        if (l0_wr === 1'b1) wr_seen++;
        check("occ_bound", (cen_seen - rd_seen) <= DEPTH, 1);
        if (done === 1'b1) begin
            done_seen++;
            check("done_width", prev_done, 0);
        end
        if (prev_done) check("busy_after_done", busy, 0);
        prev_cen_low = (sram_cen === 1'b0) && (reset === 1'b1);
        prev_done    = (done === 1'b1) && (reset === 1'b1);
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cen"}, sram_cen, 1);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_wr"}, l0_wr, 0);
        check({tag, "_rd"}, l0_rd, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Drive a start pulse; returns 1ns after the edge that samples it.
    task automatic start_xfer(input logic [AW-1:0] b, input int n);
        @(posedge clk); #1;
        base_addr = b;
        num_rows  = LW'(n);
        start     = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(b + AW'(i));
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ~b;
        num_rows  = '1;
    endtask

    // Cycles from the start edge until done is seen; busy must hold until then.
    task automatic wait_done(output int c);
        bit got = 1'b0;
        c = 0;
        while (!got && c < 400) begin
            @(negedge clk);
            check("busy_during", busy, 1);
            if (done === 1'b1) got = 1'b1;
            else c++;
        end
        if (!got) check("done_timeout", 0, 1);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int c;
        int k;
        reset = 1'b0; start = 1'b1; base_addr = 11'h3AB; num_rows = 8'd5; array_ready = 1'b1;

        // Reset held with start asserted
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_reset_vals("reset_hold");
        end
        check("reset_no_cen", cen_seen, 0);
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        clr();

        // Basic transfer
        start_xfer(11'h010, 4);
        wait_done(c);
        check("basic_done_lat", c, 4 + COL + 4);
        check("basic_cen", cen_seen, 4);
        check("basic_wr", wr_seen, 4);
        check("basic_rd", rd_seen, 4);
        check("basic_done_cnt", done_seen, 1);
        clr();

        // Backpressure
        array_ready = 1'b0;
        start_xfer(11'h200, 20);
        repeat (30) @(negedge clk);
        check("bp_cen_stall", cen_seen, DEPTH);
        check("bp_wr_stall", wr_seen, DEPTH);
        check("bp_no_rd", rd_seen, 0);
        check("bp_cen_idle", sram_cen, 1);
        @(posedge clk); #1;
        array_ready = 1'b1;
        wait_done(c);
        check("bp_cen", cen_seen, 20);
        check("bp_wr", wr_seen, 20);
        check("bp_rd", rd_seen, 20);
        check("bp_done_cnt", done_seen, 1);
        clr();

        // Zero rows
        start_xfer(11'h055, 0);
        wait_done(c);
        check("zero_done_lat", c, 1);
        check("zero_cen", cen_seen, 0);
        check("zero_wr", wr_seen, 0);
        check("zero_rd", rd_seen, 0);
        clr();

        // Address wrap
        start_xfer(11'h7FE, 3);
        wait_done(c);
        check("wrap_done_lat", c, 3 + COL + 4);
        check("wrap_cen", cen_seen, 3);
        clr();

        // Mid-operation reset
        start_xfer(11'h300, 16);
        k = 0;
        while (cen_seen < 6 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("mid_reached6", cen_seen >= 6, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(negedge clk);
        check("mid_no_trailing_wr", l0_wr, 0);
        clr();
        start_xfer(11'h400, 5);
        wait_done(c);
        check("post_reset_done_lat", c, 5 + COL + 4);
        check("post_reset_cen", cen_seen, 5);
        check("post_reset_rd", rd_seen, 5);
        clr();

        // Start while busy is ignored
        start_xfer(11'h020, 6);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 11'h100; num_rows = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(c);
        check("busy_start_done_lat", c, 6 + COL + 4 - 4);
        check("busy_start_cen", cen_seen, 6);
        check("busy_start_done_cnt", done_seen, 1);
        repeat (3) @(negedge clk);
        check("busy_start_no_rerun", cen_seen, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
